// File: rtl/irq_loopback_arbiter.sv
// IRQ loopback arbiter: captures changes of each CPU's outgoing IRQ word into a
// per-CPU FIFO and delivers at most one word per cycle back to its CPU, round-robin.
module irq_loopback_arbiter #(
    parameter int N_CPU = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CPU*32-1:0]      cpu_o_irq,
    input  logic [N_CPU-1:0]         cpu_finish,
    output logic [N_CPU*32-1:0]      cpu_i_irq,
    output logic                     grant_valid,
    output logic [$clog2(N_CPU)-1:0] grant_idx,
    output logic [N_CPU-1:0]         overflow,
    output logic                     all_finish
);
    localparam int          IW = $clog2(N_CPU);
    localparam int          PW = $clog2(DEPTH);
    localparam int unsigned NC = N_CPU;

    logic [N_CPU-1:0] push;
    logic [N_CPU-1:0] nonempty;
    logic [N_CPU-1:0] pop;
    logic             gnt_any;
    logic [IW-1:0]    gnt;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    cand;

    // Round-robin search starting just after the last granted CPU.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = last_grant;
        cand    = last_grant;
        for (int unsigned i = 1; i <= NC; i++) begin
            cand = IW'((32'(last_grant) + i) % NC);
            if (!gnt_any && nonempty[cand]) begin
                gnt_any = 1'b1;
                gnt     = cand;
            end
        end
    end

    for (genvar k = 0; k < N_CPU; k++) begin : g_cpu
        localparam logic [IW-1:0] ID   = IW'(k);
        localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

        logic [31:0]   word;
        logic [31:0]   prev_o;
        logic [31:0]   mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [PW:0]   count;
        logic          accept;
        logic [31:0]   irq_q;
        logic          ovf_q;

        assign word        = cpu_o_irq[k*32 +: 32];
        assign push[k]     = word != prev_o;
        assign nonempty[k] = count != '0;
        assign pop[k]      = gnt_any && (gnt == ID);
        // A full FIFO still takes the new word when its head leaves on the same edge.
        assign accept      = push[k] && ((count != FULL) || pop[k]);

        assign cpu_i_irq[k*32 +: 32] = irq_q;
        assign overflow[k]           = ovf_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev_o <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                irq_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                prev_o <= word;
                if (push[k] && !accept) begin
                    ovf_q <= 1'b1;
                end
                if (accept) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    irq_q  <= mem[rd_ptr];
                end
                if (accept && !pop[k]) begin
                    count <= count + (PW+1)'(1);
                end else if (pop[k] && !accept) begin
                    count <= count - (PW+1)'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (accept) begin
                mem[wr_ptr] <= word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_grant  <= IW'(N_CPU - 1);
            all_finish  <= 1'b0;
        end else begin
            grant_valid <= gnt_any;
            if (gnt_any) begin
                grant_idx  <= gnt;
                last_grant <= gnt;
            end
            all_finish <= (&cpu_finish) && !(|nonempty) && !(|push);
        end
    end

endmodule

// File: tb/tb_irq_loopback_arbiter.sv
// Scoreboard bench for irq_loopback_arbiter: a queue-based reference model predicts
// deliveries and flags; a negedge monitor compares them against the DUT.
module tb_irq_loopback_arbiter;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*32-1:0] cpu_o_irq = '0;
    logic [N-1:0]    cpu_finish = '0;
    logic [N*32-1:0] cpu_i_irq;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;
    logic [N-1:0]    overflow;
    logic            all_finish;

    irq_loopback_arbiter #(.N_CPU(N), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_o_irq  (cpu_o_irq),
        .cpu_finish (cpu_finish),
        .cpu_i_irq  (cpu_i_irq),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .overflow   (overflow),
        .all_finish (all_finish)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] word;
    } deliv_t;

    logic [31:0] m_prev [N];
    logic [31:0] m_q [N][$];
    logic [31:0] m_cpu_i [N];
    int          m_last;
    bit          m_gv;
    int          m_gi;
    bit [N-1:0]  m_ovf;
    bit          m_fin;
    deliv_t      exp_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_prev[k] = '0;
                m_cpu_i[k] = '0;
                m_q[k].delete();
            end
            m_last = N - 1;
            m_gv   = 1'b0;
            m_gi   = 0;
            m_ovf  = '0;
            m_fin  = 1'b0;
            exp_q.delete();
        end else begin
            int          pick;
            bit          anypush;
            bit          empty_all;
            logic [31:0] w;
            deliv_t      d;
            pick = -1;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (pick < 0 && m_q[c].size() > 0) pick = c;
            end
            anypush   = 1'b0;
            empty_all = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (cpu_o_irq[k*32 +: 32] != m_prev[k]) anypush = 1'b1;
                if (m_q[k].size() != 0) empty_all = 1'b0;
            end
            m_fin = (&cpu_finish) && empty_all && !anypush;
            m_gv  = (pick >= 0);
            if (pick >= 0) begin
                w = m_q[pick].pop_front();
                m_cpu_i[pick] = w;
                m_gi   = pick;
                m_last = pick;
                d.idx  = 32'(pick);
                d.word = w;
                exp_q.push_back(d);
            end
            for (int k = 0; k < N; k++) begin
                w = cpu_o_irq[k*32 +: 32];
                if (w != m_prev[k]) begin
                    if (m_q[k].size() < D) m_q[k].push_back(w);
                    else m_ovf[k] = 1'b1;
                end
                m_prev[k] = w;
            end
        end
    end

    function automatic bit model_busy();
        for (int k = 0; k < N; k++) if (m_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        deliv_t d;
        int     gi;
        check("grant_valid", 32'(grant_valid), 32'(m_gv));
        check("grant_idx", 32'(grant_idx), 32'(m_gi));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("all_finish", 32'(all_finish), 32'(m_fin));
        for (int k = 0; k < N; k++) check("cpu_i_irq", cpu_i_irq[k*32 +: 32], m_cpu_i[k]);
        if (grant_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", 32'(grant_idx), 32'hFFFF_FFFF);
            end else begin
                d  = exp_q.pop_front();
                gi = int'(grant_idx);
                check("deliv_idx", 32'(grant_idx), d.idx);
                check("deliv_word", cpu_i_irq[gi*32 +: 32], d.word);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] v);
        cpu_o_irq[k*32 +: 32] = v;
    endtask

    task automatic do_reset();
        cpu_o_irq = '0;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) check("rst_cpu_i_irq", cpu_i_irq[k*32 +: 32], 32'h0);
        check("rst_grant_valid", 32'(grant_valid), 32'h0);
        check("rst_grant_idx", 32'(grant_idx), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_all_finish", 32'(all_finish), 32'h0);
        #1 rst = 1'b0;
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        do_reset();
        step();

        // single-CPU latency
        set_word(1, 32'h1234_5678);
        step();
        @(negedge clk);
        check("lat_word", cpu_i_irq[63:32], 32'h1234_5678);
        check("lat_gv", 32'(grant_valid), 32'h1);
        check("lat_idx", 32'(grant_idx), 32'h1);
        #1;

        // round-robin with a late CPU0 change
        do_reset();
        for (int k = 0; k < N; k++) set_word(k, 32'hA000_0000 | 32'(k));
        step();
        set_word(0, 32'hB000_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_gv", 32'(grant_valid), 32'h1);
            check("rr_idx", 32'(grant_idx), 32'(rr_exp[i]));
            #1;
        end
        check("rr_late_word", cpu_i_irq[31:0], 32'hB000_0000);

        // sustained burst: every FIFO fills, overflows, and sees full+push+pop
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < N; k++) set_word(k, 32'((k << 8) | (c + 1)));
            step();
        end
        check("burst_ovf", 32'(overflow), 32'hF);
        for (int i = 0; i < 20; i++) step();

        // reset with three words pending
        do_reset();
        for (int k = 0; k < 3; k++) set_word(k, 32'hC000_0000 | 32'(k));
        step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_gv", 32'(grant_valid), 32'h0);
            #1;
        end

        // finish with one word pending on CPU3
        cpu_finish = '1;
        set_word(3, 32'hCAFE_0003);
        step();
        @(negedge clk);
        check("fin_deliv_idx", 32'(grant_idx), 32'h3);
        check("fin_wait", 32'(all_finish), 32'h0);
        #1;
        @(negedge clk);
        check("fin_set", 32'(all_finish), 32'h1);
        #1;

        // randomized traffic with one mid-run reset
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 2) == 0) set_word(k, $urandom_range(0, 5));
            cpu_finish = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            step();
        end

        // drain
        cpu_finish = '1;
        for (int i = 0; i < 100 && model_busy(); i++) step();
        step();
        step();
        check("drain_scoreboard", 32'(exp_q.size()), 32'h0);
        check("final_all_finish", 32'(all_finish), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
